sump_command_decoder: RTL and testbench
=======================================

Name: sump_command_decoder

Overview:
- Assembles SUMP protocol commands from the UART receiver byte stream.
- Presents a complete opcode plus 32-bit argument to the analyzer controller, with a one-cycle cmd_recv_rx strobe.
- Sits between uart_rx and the controller.
- Short commands (opcode < 0x80) are 1 byte. Long commands (opcode >= 0x80) are 5 bytes: opcode followed by 4 argument bytes, LSB first.

Parameters:
- TIMEOUT_CYCLES, 1000000: idle clock cycles allowed between bytes of a long command before the partial command is discarded (10 ms at 100 MHz).
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter (derived; do not override).

Ports:
- clock  in  1  system clock
- ext_reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from uart_rx
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
- rx_error  in  1  one-cycle strobe; framing/parity error on the current byte
- opcode  out  8  opcode of the last completed command
- command  out  32  argument of the last completed command; byte 1 in [7:0] through byte 4 in [31:24]
- cmd_recv_rx  out  1  one-cycle strobe; opcode/command hold a new complete command
- busy  out  1  high while a long command is partially received
- cmd_error  out  1  one-cycle strobe; partial command dropped (timeout or rx_error)

Behaviour:
- Reset (ext_reset_n low, asynchronous): state=IDLE; opcode=0x00; command=0; cmd_recv_rx=0; busy=0; cmd_error=0; byte counter=0; timeout counter=0.
- All outputs are registered.
- State IDLE:
  - rx_valid with rx_data[7]=0: opcode<=rx_data, command<=0, cmd_recv_rx=1 next cycle; stay IDLE.
  - rx_valid with rx_data[7]=1: latch byte into a shadow opcode register, clear the shadow argument, byte_cnt<=0, timeout<=0, go to ARGS.
- State ARGS (busy=1):
  - Each rx_valid writes rx_data into shadow argument byte lane byte_cnt and increments byte_cnt; timeout<=0.
  - On the 4th argument byte (byte_cnt==3 at accept): copy shadow opcode/argument to opcode/command, pulse cmd_recv_rx next cycle, return to IDLE.
  - No rx_valid: timeout increments. When timeout reaches TIMEOUT_CYCLES-1: discard the shadow, cmd_error pulses next cycle, return to IDLE. opcode/command are unchanged.
- rx_error:
  - In ARGS: discard, cmd_error pulse, go to IDLE. The errored byte is ignored even if rx_valid is high in the same cycle.
  - In IDLE: the byte is ignored; no cmd_error.
- Latency: cmd_recv_rx rises exactly 1 cycle after the rx_valid of the final byte.
- opcode/command change only in that same cycle and stay stable until the next completed command. The controller may sample them any time after the strobe.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss, including a short command immediately following a long command's last byte.
- Five 0x00 bytes (the SUMP reset sequence) yield five separate cmd_recv_rx strobes with opcode 0x00.
- Timeout counter saturates; there are no wrap-around effects. The counter is only active in ARGS.
- Mid-command asynchronous reset drops all partial state. The first byte after reset is treated as an opcode.

Test Plan:
- Short command: byte 0x02 -> 1 cycle later cmd_recv_rx=1 for one cycle, opcode=0x02, command=0x00000000, busy never high.
- Long command: bytes 0x80,0x11,0x22,0x33,0x44 (spaced 20 cycles) -> busy high from cycle after 0x80 until strobe; opcode=0x80, command=0x44332211; single strobe.
- Timeout (TIMEOUT_CYCLES=50 in bench): 0xC0,0xAA then silence -> cmd_error pulse 50 cycles after 0xAA, busy falls, opcode/command keep previous values. Next byte 0x01 -> opcode=0x01 strobe.
- rx_error mid-command: 0x81,0x01,0x02 then rx_error -> cmd_error pulse, no cmd_recv_rx. Follow with 0x04 -> opcode=0x04.
- Back-to-back: 0xC1,0xDE,0xAD,0xBE,0xEF,0x00 on consecutive cycles -> two strobes one cycle apart: (0xC1, 0xEFBEADDE) then (0x00, 0).
- Reset mid-command: 0x80,0x12 then ext_reset_n low 3 cycles -> all outputs 0. Then 0x07 -> opcode=0x07, command=0.

Source files
------------

// File: rtl/sump_command_decoder.sv
// sump_command_decoder: assembles SUMP short/long commands from the uart_rx byte stream
//
// Ports:
//   clock        system clock
//   ext_reset_n  asynchronous active-low reset
//   rx_data      received byte from uart_rx
//   rx_valid     one-cycle strobe, rx_data valid this cycle
//   rx_error     one-cycle strobe, framing/parity error on the current byte
//   opcode       opcode of the last completed command
//   command      argument of the last completed command, first argument byte in [7:0]
//   cmd_recv_rx  one-cycle strobe, opcode/command hold a new complete command
//   busy         high while a long command is partially received
//   cmd_error    one-cycle strobe, partial command dropped (timeout or rx_error)
module sump_command_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        ext_reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [7:0]  opcode,
    output logic [31:0] command,
    output logic        cmd_recv_rx,
    output logic        busy,
    output logic        cmd_error
);
    typedef enum logic {IDLE, ARGS} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] timeout;
    logic [7:0]       sh_op;
    logic [31:0]      sh_arg;

    always_ff @(posedge clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state       <= IDLE;
            opcode      <= '0;
            command     <= '0;
            cmd_recv_rx <= 1'b0;
            busy        <= 1'b0;
            cmd_error   <= 1'b0;
            byte_cnt    <= '0;
            timeout     <= '0;
            sh_op       <= '0;
            sh_arg      <= '0;
        end else begin
            cmd_recv_rx <= 1'b0;
            cmd_error   <= 1'b0;
            case (state)
                IDLE: begin
                    timeout <= '0;
                    // an errored byte in IDLE is silently ignored
                    if (rx_valid && !rx_error) begin
                        if (!rx_data[7]) begin
                            opcode      <= rx_data;
                            command     <= '0;
                            cmd_recv_rx <= 1'b1;
                        end else begin
                            sh_op    <= rx_data;
                            sh_arg   <= '0;
                            byte_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= ARGS;
                        end
                    end
                end
                ARGS: begin
                    if (rx_error) begin
                        // rx_error wins over a simultaneous rx_valid
                        cmd_error <= 1'b1;
                        busy      <= 1'b0;
                        byte_cnt  <= '0;
                        timeout   <= '0;
                        state     <= IDLE;
                    end else if (rx_valid) begin
                        sh_arg[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        timeout  <= '0;
                        if (byte_cnt == 2'd3) begin
                            // final byte bypasses the shadow so the strobe is one cycle after it
                            opcode      <= sh_op;
                            command     <= {rx_data, sh_arg[23:0]};
                            cmd_recv_rx <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (timeout == LAST) begin
                        cmd_error <= 1'b1;
                        busy      <= 1'b0;
                        byte_cnt  <= '0;
                        timeout   <= '0;
                        state     <= IDLE;
                    end else if (timeout != MAX) begin
                        timeout <= timeout + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sump_command_decoder.sv
// tb_sump_command_decoder: checks sump_command_decoder against a byte-queue reference model
module tb_sump_command_decoder;
    localparam int TO = 50;

    logic        clock = 1'b0;
    logic        ext_reset_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_error = 1'b0;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        cmd_recv_rx;
    logic        busy;
    logic        cmd_error;

    sump_command_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .ext_reset_n(ext_reset_n), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_error(rx_error), .opcode(opcode),
        .command(command), .cmd_recv_rx(cmd_recv_rx), .busy(busy),
        .cmd_error(cmd_error)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total = 0;

    // reference model: pending long command kept as a byte queue
    logic [7:0]  pend[$];
    int          idle;
    logic [7:0]  m_op;
    logic [31:0] m_cmd;
    logic        m_recv, m_busy, m_err;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        e;
        logic        recv;
        logic [7:0]  op;
        logic [31:0] cmd;
        logic        busy;
        logic        err;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        pend.delete();
        idle = 0;
        m_op = '0; m_cmd = '0; m_recv = 0; m_busy = 0; m_err = 0;
    endtask

    task automatic model(input logic v, input logic [7:0] d, input logic e);
        m_recv = 0;
        m_err = 0;
        if (pend.size() != 0) begin
            if (e) begin
                pend.delete();
                m_err = 1;
            end else if (v) begin
                pend.push_back(d);
                idle = 0;
                if (pend.size() == 5) begin
                    m_op = pend[0];
                    m_cmd = {pend[4], pend[3], pend[2], pend[1]};
                    m_recv = 1;
                    pend.delete();
                end
            end else begin
                idle++;
                if (idle == TO) begin
                    pend.delete();
                    m_err = 1;
                end
            end
        end else if (v && !e) begin
            if (d < 8'h80) begin
                m_op = d;
                m_cmd = '0;
                m_recv = 1;
            end else begin
                pend.push_back(d);
                idle = 0;
            end
        end
        m_busy = pend.size() != 0;
    endtask

    task automatic cmp_model();
        chk("opcode", 32'(opcode), 32'(m_op));
        chk("command", command, m_cmd);
        chk("cmd_recv_rx", 32'(cmd_recv_rx), 32'(m_recv));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("cmd_error", 32'(cmd_error), 32'(m_err));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic e);
        rx_valid = v;
        rx_data = d;
        rx_error = e;
        @(posedge clock);
        model(v, d, e);
        #1;
        cmp_model();
        rx_valid = 0;
        rx_error = 0;
    endtask

    task automatic do_reset();
        ext_reset_n = 0;
        model_reset();
        #2;
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_command", command, 32'h0);
        chk("rst_flags", {29'b0, cmd_recv_rx, busy, cmd_error}, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        ext_reset_n = 1;
    endtask

    initial begin
        int k;
        int strobes;
        model_reset();
        do_reset();

        // back-to-back long+short command, then the five-zero SUMP reset sequence
        tbl[0]  = '{1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'hDE, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'hAD, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'hBE, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'hEF, 1'b0, 1'b1, 8'hC1, 32'hEFBEADDE, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].e);
            chk($sformatf("tbl%0d_op", i), 32'(opcode), 32'(tbl[i].op));
            chk($sformatf("tbl%0d_cmd", i), command, tbl[i].cmd);
            chk($sformatf("tbl%0d_flags", i), {29'b0, cmd_recv_rx, busy, cmd_error},
                {29'b0, tbl[i].recv, tbl[i].busy, tbl[i].err});
        end

        // short command
        step(1, 8'h02, 0);
        chk("short_strobe", {cmd_recv_rx, busy, opcode, command}, {1'b1, 1'b0, 8'h02, 32'h0});
        step(0, 0, 0);
        chk("short_strobe_len", 32'(cmd_recv_rx), 32'h0);

        // long command spaced 20 cycles
        strobes = 0;
        foreach (tbl[i]) ;
        step(1, 8'h80, 0);
        chk("long_busy_rise", 32'(busy), 32'h1);
        for (int b = 1; b <= 4; b++) begin
            repeat (19) begin
                step(0, 0, 0);
                strobes += cmd_recv_rx;
            end
            step(1, 8'(b * 8'h11), 0);
            strobes += cmd_recv_rx;
        end
        chk("long_result", {busy, opcode, command}, {1'b0, 8'h80, 32'h44332211});
        chk("long_strobes", 32'(strobes), 32'h1);

        // timeout
        step(1, 8'hC0, 0);
        step(1, 8'hAA, 0);
        k = 0;
        while (k < 100 && !cmd_error) begin
            step(0, 0, 0);
            k++;
        end
        chk("timeout_latency", 32'(k), 32'(TO));
        chk("timeout_keep", {busy, opcode, command}, {1'b0, 8'h80, 32'h44332211});
        step(1, 8'h01, 0);
        chk("after_timeout", {cmd_recv_rx, opcode, command}, {1'b1, 8'h01, 32'h0});

        // rx_error mid-command, with rx_valid in the same cycle
        step(1, 8'h81, 0);
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 1);
        chk("rxerr_drop", {cmd_error, cmd_recv_rx, busy}, 3'b100);
        step(1, 8'h04, 0);
        chk("after_rxerr", {cmd_recv_rx, opcode, command}, {1'b1, 8'h04, 32'h0});

        // rx_error in IDLE is ignored silently
        step(1, 8'h05, 1);
        chk("idle_rxerr", {cmd_error, cmd_recv_rx, opcode}, {1'b0, 1'b0, 8'h04});

        // reset mid-command
        step(1, 8'h80, 0);
        step(1, 8'h12, 0);
        do_reset();
        step(1, 8'h07, 0);
        chk("after_reset", {cmd_recv_rx, busy, opcode, command}, {1'b1, 1'b0, 8'h07, 32'h0});

        // randomized traffic with occasional long silences to provoke timeouts
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                repeat ($urandom_range(TO - 3, TO + 3)) step(0, 0, 0);
            end else begin
                step($urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) ? 8'($urandom) : 8'($urandom_range(0, 127)),
                     $urandom_range(0, 59) == 0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
